// File: rtl/bmc_heartbeat_monitor_pkg.sv
// Shared types, default timing constants and helpers for the BMC heartbeat monitor.
package bmc_heartbeat_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_ALIVE   = 2'd2,
        ST_LOST    = 2'd3
    } hb_state_e;

    localparam int unsigned DEF_DEGLITCH_MS     = 2;
    localparam int unsigned DEF_MIN_HALF_MS     = 300;
    localparam int unsigned DEF_MAX_HALF_MS     = 700;
    localparam int unsigned DEF_LOST_TIMEOUT_MS = 3000;
    localparam int unsigned DEF_GOOD_EDGES      = 4;
    localparam int unsigned DEF_CNT_W           = 12;
    localparam int unsigned STAT_W              = 8;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] lim);
        return (val >= lim) ? lim : val + 32'd1;
    endfunction

endpackage

// File: rtl/bmc_heartbeat_monitor_hb_sync_deglitch.sv
// Synchronises the raw heartbeat pin, deglitches it on the ms tick and
// emits a one-clk pulse per accepted level change.
module bmc_heartbeat_monitor_hb_sync_deglitch
    import bmc_heartbeat_monitor_pkg::*;
#(
    parameter int unsigned DEGLITCH_MS = DEF_DEGLITCH_MS
) (
    input  logic clk,
    input  logic rst_l,
    input  logic ms_tick,
    input  logic hb_in,
    output logic edge_pulse
);

    localparam int unsigned DG_W = $clog2(DEGLITCH_MS + 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic [DG_W-1:0] dg_cnt_q, dg_cnt_d;
    logic            edge_q, edge_d;

    // Level flips once DEGLITCH_MS consecutive tick samples disagree with it.
    always_comb begin
        sync1_d  = hb_in;
        sync2_d  = sync1_q;
        level_d  = level_q;
        dg_cnt_d = dg_cnt_q;
        edge_d   = 1'b0;
        if (ms_tick) begin
            if (sync2_q == level_q) begin
                dg_cnt_d = '0;
            end else if (32'(dg_cnt_q) + 32'd1 >= 32'(DEGLITCH_MS)) begin
                level_d  = sync2_q;
                dg_cnt_d = '0;
                edge_d   = 1'b1;
            end else begin
                dg_cnt_d = dg_cnt_q + DG_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            dg_cnt_q <= '0;
            edge_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            dg_cnt_q <= dg_cnt_d;
            edge_q   <= edge_d;
        end
    end

    assign edge_pulse = edge_q;

endmodule

// File: rtl/bmc_heartbeat_monitor.sv
// Qualifies the 1 Hz BMC heartbeat into alive/lost status for BIOS failover.
// Statistics outputs are built only when BMC_HB_STATS_EN is defined.
module bmc_heartbeat_monitor
    import bmc_heartbeat_monitor_pkg::*;
#(
    parameter int unsigned DEGLITCH_MS     = DEF_DEGLITCH_MS,
    parameter int unsigned MIN_HALF_MS     = DEF_MIN_HALF_MS,
    parameter int unsigned MAX_HALF_MS     = DEF_MAX_HALF_MS,
    parameter int unsigned LOST_TIMEOUT_MS = DEF_LOST_TIMEOUT_MS,
    parameter int unsigned GOOD_EDGES      = DEF_GOOD_EDGES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              ms_tick,
    input  logic              enable,
    input  logic              hb_in,
    output logic              hb_alive,
    output logic              hb_lost,
    output logic              hb_lost_pulse,
    output logic [STAT_W-1:0] edge_count,
    output logic [CNT_W-1:0]  last_half_ms,
    output logic [STAT_W-1:0] fault_cnt
);

    localparam int unsigned GC_W = $clog2(GOOD_EDGES + 1);

    hb_state_e        state_q, state_d;
    logic [CNT_W-1:0] hp_cnt_q, hp_cnt_d;
    logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
    logic             first_q, first_d;
    logic             alive_q, alive_d;
    logic             lost_q, lost_d;
    logic             lost_pulse_q, lost_pulse_d;

    logic edge_acc;
    logic edge_valid;
    logic meas_edge;
    logic timeout;

    bmc_heartbeat_monitor_hb_sync_deglitch #(
        .DEGLITCH_MS (DEGLITCH_MS)
    ) u_sync_deglitch (
        .clk        (clk),
        .rst_l      (rst_l),
        .ms_tick    (ms_tick),
        .hb_in      (hb_in),
        .edge_pulse (edge_acc)
    );

    // An edge landing on the timeout tick wins and measures as too long.
    assign edge_valid = (32'(hp_cnt_q) >= 32'(MIN_HALF_MS)) && (32'(hp_cnt_q) <= 32'(MAX_HALF_MS));
    assign meas_edge  = edge_acc && !first_q;
    assign timeout    = (32'(hp_cnt_q) >= 32'(LOST_TIMEOUT_MS)) && !edge_acc;

    always_comb begin
        state_d      = state_q;
        hp_cnt_d     = hp_cnt_q;
        good_cnt_d   = good_cnt_q;
        first_d      = first_q;
        alive_d      = 1'b0;
        lost_d       = 1'b0;
        lost_pulse_d = 1'b0;

        if (!enable || state_q == ST_IDLE) begin
            state_d    = enable ? ST_ACQUIRE : ST_IDLE;
            hp_cnt_d   = '0;
            good_cnt_d = '0;
            first_d    = 1'b1;
        end else begin
            if (edge_acc) begin
                hp_cnt_d = '0;
                first_d  = 1'b0;
            end else if (ms_tick) begin
                hp_cnt_d = CNT_W'(sat_inc(32'(hp_cnt_q), 32'(LOST_TIMEOUT_MS)));
            end

            if (meas_edge) begin
                good_cnt_d = edge_valid ? GC_W'(sat_inc(32'(good_cnt_q), 32'(GOOD_EDGES))) : '0;
            end

            case (state_q)
                ST_ACQUIRE: begin
                    if (32'(good_cnt_d) >= 32'(GOOD_EDGES)) begin
                        state_d = ST_ALIVE;
                    end else if (timeout) begin
                        state_d    = ST_LOST;
                        good_cnt_d = '0;
                    end
                end
                ST_ALIVE: begin
                    if (meas_edge && !edge_valid) begin
                        state_d = ST_ACQUIRE;
                    end else if (timeout) begin
                        state_d    = ST_LOST;
                        good_cnt_d = '0;
                    end
                end
                ST_LOST: begin
                    if (meas_edge && edge_valid) begin
                        state_d    = ST_ACQUIRE;
                        good_cnt_d = GC_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        alive_d      = (state_d == ST_ALIVE);
        lost_d       = (state_d == ST_LOST);
        lost_pulse_d = (state_d == ST_LOST) && (state_q == ST_ACQUIRE || state_q == ST_ALIVE);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_IDLE;
            hp_cnt_q     <= '0;
            good_cnt_q   <= '0;
            first_q      <= 1'b1;
            alive_q      <= 1'b0;
            lost_q       <= 1'b0;
            lost_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_cnt_q     <= hp_cnt_d;
            good_cnt_q   <= good_cnt_d;
            first_q      <= first_d;
            alive_q      <= alive_d;
            lost_q       <= lost_d;
            lost_pulse_q <= lost_pulse_d;
        end
    end

    assign hb_alive      = alive_q;
    assign hb_lost       = lost_q;
    assign hb_lost_pulse = lost_pulse_q;

`ifdef BMC_HB_STATS_EN
    logic [STAT_W-1:0] edge_count_q, edge_count_d;
    logic [CNT_W-1:0]  last_half_q, last_half_d;
    logic [STAT_W-1:0] fault_cnt_q, fault_cnt_d;

    // The unmeasured first edge is counted but never classified.
    always_comb begin
        edge_count_d = edge_count_q;
        last_half_d  = last_half_q;
        fault_cnt_d  = fault_cnt_q;
        if (!enable || state_q == ST_IDLE) begin
            edge_count_d = '0;
            last_half_d  = '0;
            fault_cnt_d  = '0;
        end else if (edge_acc) begin
            edge_count_d = STAT_W'(sat_inc(32'(edge_count_q), 32'({STAT_W{1'b1}})));
            if (!first_q) begin
                last_half_d = hp_cnt_q;
                if (!edge_valid) begin
                    fault_cnt_d = STAT_W'(sat_inc(32'(fault_cnt_q), 32'({STAT_W{1'b1}})));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            edge_count_q <= '0;
            last_half_q  <= '0;
            fault_cnt_q  <= '0;
        end else begin
            edge_count_q <= edge_count_d;
            last_half_q  <= last_half_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign edge_count   = edge_count_q;
    assign last_half_ms = last_half_q;
    assign fault_cnt    = fault_cnt_q;
`else
    assign edge_count   = '0;
    assign last_half_ms = '0;
    assign fault_cnt    = '0;
`endif

endmodule

// File: doc/bmc_heartbeat_monitor.md
Name: bmc_heartbeat_monitor

Overview:
- Qualifies the BMC heartbeat, a 1 Hz square wave driven onto a CPLD GPIO.
- Produces clean alive/lost status for the BIOS failover state machine, which is the downstream consumer.
- Replaces a bare "waveform present" check with half-period window validation, an acquisition phase and loss detection.
- Time base is the shared 1 ms tick pulse from the timer chain.

Parameters:
- DEGLITCH_MS, 2: consecutive equal ms samples required before a new input level is accepted.
- MIN_HALF_MS, 300: shortest valid half-period, in ms, inclusive.
- MAX_HALF_MS, 700: longest valid half-period, in ms, inclusive.
- LOST_TIMEOUT_MS, 3000: ms without an accepted edge before the heartbeat is declared lost.
- GOOD_EDGES, 4: consecutive valid half-periods required to declare the heartbeat alive.
- CNT_W, 12: width of the half-period counter. It must hold LOST_TIMEOUT_MS.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_l  in  1  reset; asynchronous, active-low
- ms_tick  in  1  single-clk pulse, once per ms
- enable  in  1  monitor enable; 0 forces IDLE
- hb_in  in  1  raw heartbeat pin, asynchronous
- hb_alive  out  1  heartbeat qualified good
- hb_lost  out  1  heartbeat timed out; level output
- hb_lost_pulse  out  1  single-clk pulse on entry to LOST
- edge_count  out  8  accepted edges since enable; saturates at 255
- last_half_ms  out  CNT_W  most recently measured half-period
- fault_cnt  out  8  invalid half-periods seen; saturates at 255

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, debounced level 0.
- Input path:
  - hb_in passes through a 2-flop synchroniser.
  - It is sampled only on ms_tick.
  - The debounced level changes after DEGLITCH_MS consecutive tick samples differ from the current level.
  - An accepted edge is a one-clk event in the clk cycle after the qualifying tick.
  - Latency from pin to edge: 2 clk plus DEGLITCH_MS ticks plus 1 clk.
- Half-period counter (hp_cnt):
  - Increments on ms_tick and saturates at LOST_TIMEOUT_MS.
  - Cleared on every accepted edge and on IDLE exit.
- Edge classification: valid when MIN_HALF_MS <= hp_cnt <= MAX_HALF_MS, otherwise invalid.
- First-edge rule: the first accepted edge after entering ACQUIRE from IDLE is unmeasured. It only restarts hp_cnt and is not classified.
- Counter and output updates on edges:
  - good_cnt: +1 on a valid edge, saturating at GOOD_EDGES; cleared to 0 on an invalid edge.
  - fault_cnt: +1 on each invalid edge.
  - edge_count: +1 on every accepted edge, including the unmeasured first edge.
  - last_half_ms: loads hp_cnt on every classified edge.
- FSM states: IDLE, ACQUIRE, ALIVE, LOST.
  - IDLE: outputs 0 and counters cleared. enable=1 moves to ACQUIRE.
  - ACQUIRE: good_cnt reaching GOOD_EDGES moves to ALIVE. hp_cnt reaching LOST_TIMEOUT_MS moves to LOST.
  - ALIVE: hb_alive=1. An invalid edge moves to ACQUIRE with good_cnt=0. Timeout moves to LOST.
  - LOST: hb_lost=1. A valid edge moves to ACQUIRE with good_cnt=1. Invalid edges keep the state LOST.
  - Any state: enable=0 moves to IDLE on the next clk, taking priority over everything.
- hb_lost_pulse: exactly one clk on each ACQUIRE→LOST or ALIVE→LOST transition.
- Simultaneous edge and timeout on the same tick: the edge wins and is classified invalid (hp_cnt > MAX), so there is no LOST transition.
- hp_cnt saturating: no wrap. LOST is held until an edge arrives.
- rst_l asserted mid-operation: immediate return to the reset values. No pulse is emitted.

Optional Feature:
- Macro: BMC_HB_STATS_EN.
- When defined: last_half_ms, fault_cnt and edge_count registers are implemented as above.
- When undefined: these three outputs are tied to 0 and their registers are removed. FSM, hb_alive and hb_lost are unchanged.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=0, ACQUIRE=1, ALIVE=2, LOST=3.
  - Default timing constants: 300, 700, 3000 ms.
  - A saturating-increment helper function.
- Natural sub-module: hb_sync_deglitch, covering the synchroniser, tick-sampled deglitch and edge pulse. The FSM and counters stay in the top.

Test Plan:
- 500/500 ms square wave, enable=1 at t0 → first edge unmeasured; hb_alive=1 after the 5th accepted edge (~2.5 s); last_half_ms=500; fault_cnt=0.
- Stop toggling while ALIVE → hb_lost=1 and hb_lost_pulse for exactly 1 clk at 3000 ms after the last edge; hb_alive=0.
- 100/100 ms square wave → never ALIVE; fault_cnt increments every edge and saturates at 255.
- 1 ms glitch on a steady hb_in → no edge, edge_count unchanged; with DEGLITCH_MS=2, a 2 ms pulse is accepted.
- While ALIVE: one 800 ms half-period → ACQUIRE, good_cnt=0; four further 500 ms halves → ALIVE again.
- enable=0 mid-ALIVE → next clk all outputs 0. rst_l pulse mid-ACQUIRE → all outputs 0, no hb_lost_pulse.
